// File: rtl/clk_divider.sv
// clk_divider: programmable square-wave generator in the clk domain.
// The half-period N = floor(CLK_FREQ_HZ / (2*speed)), clamped to at least 1,
// is computed by a multi-cycle restoring divider whenever speed changes.
// Optional build macro: CLKDIV_ROUND_EN selects round-to-nearest
// (N = floor((CLK_FREQ_HZ + speed) / (2*speed)), 33-bit dividend, 33 iterations).
module clk_divider #(
  parameter logic [31:0] CLK_FREQ_HZ = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] speed,
  output logic        outClk_d
);

`ifdef CLKDIV_ROUND_EN
  localparam int DVD_W = 33;
`else
  localparam int DVD_W = 32;
`endif
  localparam int ITER_W = 6;
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(DVD_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_LOAD} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [19:0]       r_spd_q;
  logic              r_busy;
  logic [31:0]       r_lim_q;
  logic              r_lim_vld;
  logic [31:0]       r_cnt;

  logic [ITER_W-1:0] r_iter;
  logic [DVD_W-1:0]  r_dvd;
  logic [DVD_W-1:0]  r_quo;
  logic [20:0]       r_rem;

  logic              w_spd_zero;
  logic              w_spd_chg;
  logic              w_start;
  logic              w_step;
  logic              w_load;
  logic [DVD_W-1:0]  w_dividend;
  logic [20:0]       w_divisor;
  logic [21:0]       w_rem_sh;
  logic              w_qbit;
  logic [20:0]       w_rem_nxt;

  // Half-period clamp: a zero quotient (speed above CLK_FREQ_HZ/2) becomes 1;
  // the widened rounding quotient saturates to 32 bits.
  function automatic logic [31:0] f_clamp_n(input logic [DVD_W-1:0] q);
    if (q == '0) return 32'd1;
`ifdef CLKDIV_ROUND_EN
    if (q[DVD_W-1]) return 32'hFFFF_FFFF;
`endif
    return q[31:0];
  endfunction

  assign w_spd_zero = (speed == 20'd0);
  assign w_spd_chg  = (speed != r_spd_q);

`ifdef CLKDIV_ROUND_EN
  assign w_dividend = {1'b0, CLK_FREQ_HZ} + {13'd0, speed};
`else
  assign w_dividend = CLK_FREQ_HZ;
`endif

  // One restoring step: the partial remainder is 22 bits during the compare,
  // but the kept remainder is always below the 21-bit divisor.
  assign w_divisor = {r_spd_q, 1'b0};
  assign w_rem_sh  = {r_rem, r_dvd[DVD_W-1]};
  assign w_qbit    = (w_rem_sh >= {1'b0, w_divisor});
  assign w_rem_nxt = w_qbit ? (w_rem_sh[20:0] - w_divisor) : w_rem_sh[20:0];

  // Controller next state: disable and speed changes pre-empt any state.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_step      = 1'b0;
    w_load      = 1'b0;
    if (w_spd_zero) begin
      w_state_nxt = S_IDLE;
    end else if (w_spd_chg) begin
      w_start     = 1'b1;
      w_state_nxt = S_DIV;
    end else begin
      w_step = r_busy;
      case (r_state)
        S_DIV:   if (r_iter == LAST_ITER) w_state_nxt = S_LOAD;
        S_LOAD: begin
          w_load      = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  // Control state, active limit and output counter; the old limit keeps
  // running while a division is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_spd_q   <= '0;
      r_busy    <= 1'b0;
      r_lim_q   <= '0;
      r_lim_vld <= 1'b0;
      r_cnt     <= '0;
      outClk_d  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_DIV);
      if (w_spd_zero) begin
        r_spd_q   <= '0;
        r_lim_vld <= 1'b0;
        r_cnt     <= '0;
        outClk_d  <= 1'b0;
      end else begin
        if (w_start) r_spd_q <= speed;
        if (w_load) begin
          r_lim_q   <= f_clamp_n(r_quo);
          r_lim_vld <= 1'b1;
          r_cnt     <= '0;
        end else if (r_lim_vld) begin
          if (r_cnt == r_lim_q - 32'd1) begin
            r_cnt    <= '0;
            outClk_d <= ~outClk_d;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
      end
    end
  end

  // Divider datapath: seeded on a start, one quotient bit per DIV cycle.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_dvd  <= w_dividend;
      r_quo  <= '0;
      r_rem  <= '0;
      r_iter <= '0;
    end else if (w_step) begin
      r_dvd  <= {r_dvd[DVD_W-2:0], 1'b0};
      r_quo  <= {r_quo[DVD_W-2:0], w_qbit};
      r_rem  <= w_rem_nxt;
      r_iter <= r_iter + ITER_W'(1);
    end
  end

endmodule

// File: tb/tb_clk_divider.sv
// Bench for clk_divider: table of speeds with expected half-periods, hand
// sequences for disable / abort / reset mid-operation, and a randomized phase
// checked cycle by cycle against a behavioural model of the main instance.
module tb_clk_divider;

  localparam logic [31:0] F_MAIN  = 32'd50_000_000;
  localparam logic [31:0] F_SMALL = 32'd1_000_000;
`ifdef CLKDIV_ROUND_EN
  localparam int ITERS = 33;
`else
  localparam int ITERS = 32;
`endif
  localparam int NV = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] speed_m = 20'd0;
  logic [19:0] speed_s = 20'd0;
  logic        out_m;
  logic        out_s;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always #10 clk = ~clk;

  clk_divider #(.CLK_FREQ_HZ(F_MAIN)) dut (
    .clk(clk), .rst(rst), .speed(speed_m), .outClk_d(out_m)
  );

  // Second instance at a scaled-down clock so that clamp and rounding cases
  // are reachable with a 20-bit speed.
  clk_divider #(.CLK_FREQ_HZ(F_SMALL)) dut_s (
    .clk(clk), .rst(rst), .speed(speed_s), .outClk_d(out_s)
  );

  // ---------------- behavioural reference (main instance) ----------------
  function automatic longint half_period(input longint f, input longint s);
    longint q;
`ifdef CLKDIV_ROUND_EN
    q = (f + s) / (2 * s);
`else
    q = f / (2 * s);
`endif
    return (q == 0) ? 1 : q;
  endfunction

  longint m_spd = 0, m_timer = 0, m_lim = 0, m_cnt = 0;
  bit     m_pend = 0, m_vld = 0, m_out = 0;

  always @(posedge clk) begin
    bit do_load;
    do_load = 0;
    if (rst) begin
      m_spd = 0; m_pend = 0; m_timer = 0; m_vld = 0; m_lim = 0; m_cnt = 0; m_out = 0;
    end else if (speed_m == 0) begin
      m_spd = 0; m_pend = 0; m_vld = 0; m_cnt = 0; m_out = 0;
    end else begin
      if (longint'(speed_m) != m_spd) begin
        m_spd = longint'(speed_m); m_pend = 1; m_timer = ITERS + 1;
      end else if (m_pend) begin
        m_timer = m_timer - 1;
        if (m_timer == 0) begin m_pend = 0; do_load = 1; end
      end
      if (do_load) begin
        m_lim = half_period(longint'(F_MAIN), m_spd); m_vld = 1; m_cnt = 0;
      end else if (m_vld) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == m_lim) begin m_cnt = 0; m_out = !m_out; end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    chk("out_vs_model", 64'(out_m), 64'(m_out));
    chk("cnt_vs_model", 64'(dut.r_cnt), 64'(m_cnt));
  endtask

  // Steps until the selected output equals lvl; n = edges taken (= limit on timeout).
  task automatic edges_until(input bit sel, input logic lvl, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while ((((sel ? out_s : out_m)) !== lvl) && (n < limit));
  endtask

  typedef struct {
    bit          sel;
    logic [19:0] spd;
    int          n_trunc;
    int          n_round;
  } vec_t;

  vec_t vecs[NV];

  initial begin
    int n, ex, stale, load_at, seen_high;

    vecs[0]  = '{1'b0, 20'd1_000_000, 25, 25};
    vecs[1]  = '{1'b0, 20'd500_000,   50, 50};
    vecs[2]  = '{1'b0, 20'd100_000,   250, 250};
    vecs[3]  = '{1'b0, 20'd1_048_575, 23, 24};
    vecs[4]  = '{1'b0, 20'd900_000,   27, 28};
    vecs[5]  = '{1'b1, 20'd140_000,   3, 4};
    vecs[6]  = '{1'b1, 20'd600_000,   1, 1};
    vecs[7]  = '{1'b1, 20'd500_001,   1, 1};
    vecs[8]  = '{1'b1, 20'd250_000,   2, 2};
    vecs[9]  = '{1'b1, 20'd1_048_575, 1, 1};
    vecs[10] = '{1'b1, 20'd300_000,   1, 2};

    // Reset state
    speed_m = 20'd1_000_000;
    rst = 1'b1;
    step();
    step();
    chk("rst_out",   64'(out_m), 64'(0));
    chk("rst_cnt",   64'(dut.r_cnt), 64'(0));
    chk("rst_lim",   64'(dut.r_lim_q), 64'(0));
    chk("rst_vld",   64'(dut.r_lim_vld), 64'(0));
    chk("rst_busy",  64'(dut.r_busy), 64'(0));
    chk("rst_spd",   64'(dut.r_spd_q), 64'(0));

    // Table: start-up latency and both half-periods
    for (int i = 0; i < NV; i++) begin
`ifdef CLKDIV_ROUND_EN
      ex = vecs[i].n_round;
`else
      ex = vecs[i].n_trunc;
`endif
      if (vecs[i].sel) speed_s = vecs[i].spd;
      else             speed_m = vecs[i].spd;
      rst = 1'b1;
      step();
      rst = 1'b0;
      edges_until(vecs[i].sel, 1'b1, 4000, n);
      chk($sformatf("first_rise[%0d]", i), 64'(n), 64'(ITERS + 2 + ex));
      edges_until(vecs[i].sel, 1'b0, 4000, n);
      chk($sformatf("high_len[%0d]", i), 64'(n), 64'(ex));
      edges_until(vecs[i].sel, 1'b1, 4000, n);
      chk($sformatf("low_len[%0d]", i), 64'(n), 64'(ex));
    end

    // Disable while high, hold low, then restore
    speed_m = 20'd1_000_000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    edges_until(1'b0, 1'b1, 4000, n);
    speed_m = 20'd0;
    step();
    chk("disable_out", 64'(out_m), 64'(0));
    chk("disable_cnt", 64'(dut.r_cnt), 64'(0));
    seen_high = 0;
    repeat (40) begin
      step();
      if (out_m !== 1'b0) seen_high = 1;
    end
    chk("disable_hold", 64'(seen_high), 64'(0));
    speed_m = 20'd1_000_000;
    edges_until(1'b0, 1'b1, 4000, n);
    chk("restore_rise", 64'(n), 64'(ITERS + 2 + 25));

    // Abort mid-division: 800k running, 1M requested, 500k arrives during DIV
    speed_m = 20'd800_000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (ITERS + 2 + 40) step();
    chk("abort_old_lim", 64'(dut.r_lim_q), 64'(31));
    speed_m = 20'd1_000_000;
    step();
    repeat (10) step();
    speed_m = 20'd500_000;
    stale = 0;
    load_at = 0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (dut.r_lim_q == 32'd25) stale = 1;
      if (load_at == 0 && dut.r_lim_q == 32'd50) load_at = k;
    end
    chk("abort_no_stale", 64'(stale), 64'(0));
    chk("abort_load_at", 64'(load_at), 64'(ITERS + 2));
    edges_until(1'b0, 1'b0, 4000, n);
    edges_until(1'b0, 1'b1, 4000, n);
    edges_until(1'b0, 1'b0, 4000, n);
    chk("abort_high_len", 64'(n), 64'(50));
    edges_until(1'b0, 1'b1, 4000, n);
    chk("abort_low_len", 64'(n), 64'(50));

    // Reset while the output is high and a division is running
    speed_m = 20'd1_000_000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    edges_until(1'b0, 1'b0, 4000, n);
    edges_until(1'b0, 1'b1, 4000, n);
    speed_m = 20'd300_000;
    repeat (5) step();
    chk("mid_pre_out", 64'(out_m), 64'(1));
    chk("mid_pre_busy", 64'(dut.r_busy), 64'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_out", 64'(out_m), 64'(0));
    chk("mid_rst_cnt", 64'(dut.r_cnt), 64'(0));
    chk("mid_rst_vld", 64'(dut.r_lim_vld), 64'(0));
    edges_until(1'b0, 1'b1, 4000, n);
    chk("mid_rst_rise", 64'(n), 64'(ITERS + 2 + 83));

    // Randomized speed changes, disables and reset pulses against the model
    for (int s = 0; s < 150; s++) begin
      int kind;
      int dur;
      kind = int'($urandom_range(0, 9));
      dur  = int'($urandom_range(1, 120));
      if (kind == 0)      speed_m = 20'd0;
      else if (kind == 1) speed_m = 20'($urandom_range(1, 1_048_575));
      else if (kind <= 7) speed_m = 20'($urandom_range(500_000, 1_048_575));
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      repeat (dur) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
